me_lsu: RTL and testbench

Memory-stage load/store unit that consumes the EX/ME pipeline register outputs and performs the data access on the data-memory bus. Stalls the pipeline while an access is outstanding. Provides byte-lane steering, load sign/zero extension and the registered ME/WB values (write-back value, write enable, destination data).

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 65 ++++++
 rtl/me_lsu.sv | 162 ++++++++++++++++
 tb/tb_me_lsu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] STRB_B0  = 4'b0001;
    localparam logic [3:0] STRB_LO  = 4'b0011;
    localparam logic [3:0] STRB_HI  = 4'b1100;
    localparam logic [3:0] STRB_ALL = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, load extension and misalign detect.
// MISALIGN_TRAP_EN enables the misalign flag; otherwise it is 0.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] sdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ldata,
    output logic            mis
);

    logic       is_b;
    logic       is_h;
    logic       is_w;
    logic [1:0] eoff;
    logic [7:0] b;
    logic [15:0] h;

    assign is_b = size == SZ_BYTE;
    assign is_h = size == SZ_HALF;
    assign is_w = !is_b && !is_h;

    // Offset bits below the access size are dropped.
    assign eoff = off & (is_w ? 2'b00 : (is_h ? 2'b10 : 2'b11));

`ifdef MISALIGN_TRAP_EN
    assign mis = (is_h && off[0]) || (is_w && (off != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign b = rdata[{eoff, 3'b000} +: 8];
    assign h = rdata[{eoff[1], 4'b0000} +: 16];

    always_comb begin
        wstrb = STRB_ALL;
        wdata = sdata;
        ldata = rdata;
        unique case (1'b1)
            is_b: begin
                wstrb = STRB_B0 << eoff;
                wdata = {(XLEN/8){sdata[7:0]}};
                ldata = {{(XLEN-8){~uns & b[7]}}, b};
            end
            is_h: begin
                wstrb = eoff[1] ? STRB_HI : STRB_LO;
                wdata = {(XLEN/16){sdata[15:0]}};
                ldata = {{(XLEN-16){~uns & h[15]}}, h};
            end
            is_w: begin
                wstrb = STRB_ALL;
                wdata = sdata;
                ldata = rdata;
            end
        endcase
    end

endmodule

// File: rtl/me_lsu.sv
// Memory-stage load/store unit: bus FSM and ME/WB registers.
// MISALIGN_TRAP_EN traps misaligned accesses instead of issuing them.
module me_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_r,
    input  logic            mem_w,
    input  logic [1:0]      mem_size,
    input  logic            mem_unsigned,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] val_out,
    input  logic            reg_w,
    input  logic [XLEN-1:0] reg_data,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [3:0]      dbus_wstrb,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            stall,
    output logic [XLEN-1:0] wb_val,
    output logic            wb_reg_w,
    output logic [XLEN-1:0] wb_reg_data,
    output logic            bus_err,
    output logic            misalign
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [1:0]      q_size;
    logic [1:0]      q_off;
    logic            q_uns;
    logic            q_regw;
    logic [XLEN-1:0] q_regd;
    logic [XLEN-1:0] q_val;
    logic [XLEN-1:0] ld_q;

    logic            idle;
    logic            access;
    logic            trap;
    logic [1:0]      a_size;
    logic [1:0]      a_off;
    logic            a_uns;
    logic [3:0]      st_strb;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_val;
    logic            mis;

    assign idle   = state == ST_IDLE;
    assign access = mem_r | mem_w;

    // Live request steers stores in IDLE; held request steers loads.
    assign a_size = idle ? mem_size : q_size;
    assign a_off  = idle ? mem_addr[1:0] : q_off;
    assign a_uns  = idle ? mem_unsigned : q_uns;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size  (a_size),
        .uns   (a_uns),
        .off   (a_off),
        .sdata (mem_data),
        .rdata (dbus_rdata),
        .wstrb (st_strb),
        .wdata (st_data),
        .ldata (ld_val),
        .mis   (mis)
    );

    assign trap     = idle && access && mis;
    assign dbus_req = state == ST_ISSUE;
    assign stall    = !rst && ((state == ST_ISSUE)
                            || (state == ST_WAIT)
                            || (idle && access && !trap));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            q_size      <= '0;
            q_off       <= '0;
            q_uns       <= 1'b0;
            q_regw      <= 1'b0;
            q_regd      <= '0;
            q_val       <= '0;
            ld_q        <= '0;
            dbus_we     <= 1'b0;
            dbus_addr   <= '0;
            dbus_wstrb  <= '0;
            dbus_wdata  <= '0;
            wb_val      <= '0;
            wb_reg_w    <= 1'b0;
            wb_reg_data <= '0;
            bus_err     <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            bus_err  <= 1'b0;
            misalign <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (access && !trap) begin
                        dbus_we    <= mem_w;
                        dbus_addr  <= {mem_addr[XLEN-1:2], 2'b00};
                        dbus_wstrb <= mem_w ? st_strb : 4'b0000;
                        dbus_wdata <= st_data;
                        q_size     <= mem_size;
                        q_off      <= mem_addr[1:0];
                        q_uns      <= mem_unsigned;
                        q_regw     <= reg_w;
                        q_regd     <= reg_data;
                        q_val      <= val_out;
                        ld_q       <= '0;
                        state      <= ST_ISSUE;
                    end else begin
                        wb_val      <= val_out;
                        wb_reg_w    <= reg_w & ~trap;
                        wb_reg_data <= reg_data;
                        misalign    <= trap;
                    end
                end
                ST_ISSUE: begin
                    if (dbus_gnt) begin
                        cnt   <= '0;
                        state <= dbus_we ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dbus_rvalid) begin
                        ld_q  <= ld_val;
                        state <= ST_DONE;
                    end else if (cnt == TMO) begin
                        ld_q    <= '0;
                        bus_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    wb_val      <= dbus_we ? q_val : ld_q;
                    wb_reg_w    <= q_regw;
                    wb_reg_data <= q_regd;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_lsu.sv
// Randomised self-checking bench for me_lsu against a
// transaction-level model of the memory stage.
module tb_me_lsu;

    localparam int XLEN = 32;
    localparam int TMO  = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_r;
    logic            mem_w;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] val_out;
    logic            reg_w;
    logic [XLEN-1:0] reg_data;
    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [3:0]      dbus_wstrb;
    logic [XLEN-1:0] dbus_wdata;
    logic            dbus_gnt;
    logic            dbus_rvalid;
    logic [XLEN-1:0] dbus_rdata;
    logic            stall;
    logic [XLEN-1:0] wb_val;
    logic            wb_reg_w;
    logic [XLEN-1:0] wb_reg_data;
    logic            bus_err;
    logic            misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    me_lsu #(
        .XLEN(XLEN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r       (mem_r),
        .mem_w       (mem_w),
        .mem_size    (mem_size),
        .mem_unsigned(mem_unsigned),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .val_out     (val_out),
        .reg_w       (reg_w),
        .reg_data    (reg_data),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wstrb  (dbus_wstrb),
        .dbus_wdata  (dbus_wdata),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata),
        .stall       (stall),
        .wb_val      (wb_val),
        .wb_reg_w    (wb_reg_w),
        .wb_reg_data (wb_reg_data),
        .bus_err     (bus_err),
        .misalign    (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_strb(input logic [1:0] sz,
                                          input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                            input logic [31:0] d);
        if (sz == 2'd0) return d[7:0] * 32'h01010101;
        if (sz == 2'd1) return d[15:0] * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz,
                                           input logic [31:0] a,
                                           input logic [31:0] rd,
                                           input bit uns);
        int unsigned v;
        int bits;
        if (sz[1]) return rd;
        bits = (sz == 2'd0) ? 8 : 16;
        if (sz == 2'd0) v = (rd >> (8 * a[1:0])) % 256;
        else v = (rd >> (16 * a[1])) % 65536;
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    task automatic go_idle();
        mem_r = 1'b0;
        mem_w = 1'b0;
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
    endtask

    // One pipeline instruction through ME; bus answers after gdly/rdly.
    task automatic do_txn(input bit r, input bit w, input logic [1:0] sz,
                          input bit uns, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] valo,
                          input bit regw, input logic [31:0] regd,
                          input logic [31:0] rdata, input int gdly,
                          input int rdly);
        logic [31:0] exp_v;
        bit tmo;
        int wlen;
        @(negedge clk);
        mem_r = r;
        mem_w = w;
        mem_size = sz;
        mem_unsigned = uns;
        mem_addr = addr;
        mem_data = data;
        val_out = valo;
        reg_w = regw;
        reg_data = regd;
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
        #1;
        if (!(r || w)) begin
            chk("nomem_stall", stall, 0);
            @(negedge clk);
            chk("nomem_val", wb_val, valo);
            chk("nomem_regw", wb_reg_w, regw);
            chk("nomem_regd", wb_reg_data, regd);
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if ((sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'b00)) begin
            chk("trap_stall", stall, 0);
            @(negedge clk);
            chk("trap_pulse", misalign, 1);
            chk("trap_req", dbus_req, 0);
            chk("trap_regw", wb_reg_w, 0);
            go_idle();
            #1;
            chk("trap_stall2", stall, 0);
            return;
        end
`endif
        chk("req_stall", stall, 1);
        for (int c = 0; c <= gdly; c++) begin
            @(negedge clk);
            dbus_gnt = (c == gdly);
            dbus_rvalid = 1'($urandom);
            dbus_rdata = $urandom;
            #1;
            chk("iss_req", dbus_req, 1);
            chk("iss_stall", stall, 1);
            chk("iss_we", dbus_we, w);
            chk("iss_addr", dbus_addr, {addr[31:2], 2'b00});
            if (w) begin
                chk("iss_strb", dbus_wstrb, m_strb(sz, addr));
                chk("iss_wdata", dbus_wdata, m_wdata(sz, data));
            end
        end
        tmo = 1'b0;
        exp_v = valo;
        if (!w) begin
            tmo = (rdly < 0) || (rdly > TMO);
            wlen = tmo ? TMO + 1 : rdly + 1;
            exp_v = tmo ? 32'h0 : m_load(sz, addr, rdata, uns);
            for (int k = 0; k < wlen; k++) begin
                @(negedge clk);
                dbus_gnt = 1'b0;
                dbus_rvalid = !tmo && (k == rdly);
                dbus_rdata = dbus_rvalid ? rdata : $urandom;
                #1;
                chk("wait_stall", stall, 1);
                if (k == 0) chk("wait_req", dbus_req, 0);
            end
        end
        @(negedge clk);
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'($urandom);
        dbus_rdata = $urandom;
        #1;
        chk("done_stall", stall, 0);
        chk("done_req", dbus_req, 0);
        chk("done_buserr", bus_err, tmo);
        @(negedge clk);
        go_idle();
        chk("wb_val", wb_val, exp_v);
        chk("wb_regw", wb_reg_w, regw);
        chk("wb_regd", wb_reg_data, regd);
        chk("wb_buserr", bus_err, 0);
        chk("wb_misalign", misalign, 0);
    endtask

    initial begin
        bit r, w, uns, regw;
        logic [1:0] sz;
        rst = 1'b1;
        go_idle();
        mem_size = '0;
        mem_unsigned = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        val_out = '0;
        reg_w = 1'b0;
        reg_data = '0;
        dbus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", dbus_req, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_strb", dbus_wstrb, 0);
        chk("rst_wdata", dbus_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_wbval", wb_val, 0);
        chk("rst_wbregw", wb_reg_w, 0);
        chk("rst_wbregd", wb_reg_data, 0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_misalign", misalign, 0);
        rst = 1'b0;

        do_txn(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h00001234, 1, 32'd5,
               32'h0, 0, 0);
        do_txn(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h11, 0, 32'd0,
               32'h0, 1, 0);
        do_txn(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h22, 1, 32'd7,
               32'h80FF0000, 0, 1);
        do_txn(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h22, 1, 32'd7,
               32'h80FF0000, 2, 0);
        do_txn(0, 1, 2'd1, 0, 32'h102, 32'h0000ABCD, 32'h33, 0, 32'd0,
               32'h0, 0, 0);
        do_txn(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h44, 1, 32'd3,
               32'h12345678, 0, 0);
        do_txn(1, 0, 2'd1, 0, 32'h2002, 32'h0, 32'h45, 1, 32'd4,
               32'h8001FFFF, 0, 2);
        do_txn(1, 1, 2'd3, 0, 32'h300, 32'hCAFEF00D, 32'h55, 0, 32'd9,
               32'h0, 0, 0);
        do_txn(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h66, 1, 32'd2,
               32'h0BADBEEF, 0, -1);

        // Reset while a granted load is waiting for data.
        @(negedge clk);
        mem_r = 1'b1;
        mem_size = 2'd2;
        mem_addr = 32'h200;
        reg_w = 1'b1;
        reg_data = 32'd9;
        @(negedge clk);
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_stall", stall, 1);
        rst = 1'b1;
        dbus_gnt = 1'b1;
        dbus_rvalid = 1'b1;
        #1;
        chk("mid_rst_req", dbus_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_wbval", wb_val, 0);
        chk("mid_rst_wbregw", wb_reg_w, 0);
        chk("mid_rst_wbregd", wb_reg_data, 0);
        @(negedge clk);
        go_idle();
        rst = 1'b0;
        do_txn(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h77, 1, 32'd1,
               32'h0, 0, 0);
        do_txn(1, 0, 2'd1, 1, 32'h502, 32'h0, 32'h88, 1, 32'd6,
               32'hF00DBEEF, 1, 1);

        for (int i = 0; i < 80; i++) begin
            r = 1'($urandom);
            w = 1'($urandom);
            uns = 1'($urandom);
            regw = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            do_txn(r, w, sz, uns, $urandom, $urandom, $urandom, regw,
                   $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
